// File: rtl/state_ram_24x16_if.sv
// Write/read port bundle for state_ram_24x16; master drives address/data/enables, slave returns q.
interface state_ram_24x16_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] data;
  logic              we;
  logic              wr_clock_en;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_clock_en;
  logic [DATA_W-1:0] q;

  modport master (
    output wr_address, data, we, wr_clock_en, rd_address, rd_clock_en,
    input  q
  );

  modport slave (
    input  wr_address, data, we, wr_clock_en, rd_address, rd_clock_en,
    output q
  );
endinterface

// File: rtl/state_ram_24x16.sv
// 16x24 simple dual-port flop RAM, 1-cycle registered read; read-first, or write-first with RAM_BYPASS_EN.
// No backpressure: both port enables are sampled on every rising edge; reset clears array and q.
module state_ram_24x16 #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 4
) (
  input  logic               clock_200,
  input  logic               reset_n,
  state_ram_24x16_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_fire;
  logic [DATA_W-1:0] rd_word;

  assign wr_fire = bus.we && bus.wr_clock_en;

`ifdef RAM_BYPASS_EN
  // Write-first: forward the incoming word on a same-address collision.
  always_comb begin
    rd_word = mem[bus.rd_address];
    if (wr_fire && (bus.wr_address == bus.rd_address)) begin
      rd_word = bus.data;
    end
  end
`else
  always_comb begin
    rd_word = mem[bus.rd_address];
  end
`endif

  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[bus.wr_address] <= bus.data;
    end
  end

  always_ff @(posedge clock_200 or negedge reset_n) begin
    if (!reset_n) begin
      bus.q <= '0;
    end else if (bus.rd_clock_en) begin
      bus.q <= rd_word;
    end
  end
endmodule

// File: tb/tb_state_ram_24x16.sv
// Randomized and directed bench for state_ram_24x16 against a word-array reference model.
`timescale 1ns/1ps
module tb_state_ram_24x16;
  logic clock_200 = 1'b0;
  logic reset_n   = 1'b0;

  state_ram_24x16_if #(.DATA_W(24), .ADDR_W(4)) bus ();

  state_ram_24x16 #(.DATA_W(24), .ADDR_W(4)) dut (
    .clock_200 (clock_200),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clock_200 = ~clock_200;

`ifdef RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic [23:0] model [16];
  logic [23:0] q_exp;

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 24'd0;
    q_exp = 24'd0;
  endtask

  // Predict the edge from current inputs, then advance to just after it.
  task automatic cycle();
    logic [23:0] q_next;
    logic        wr;
    wr = bus.we && bus.wr_clock_en;
    q_next = q_exp;
    if (bus.rd_clock_en) begin
      if (BYPASS && wr && bus.wr_address == bus.rd_address) q_next = bus.data;
      else q_next = model[bus.rd_address];
    end
    if (wr) model[bus.wr_address] = bus.data;
    q_exp = q_next;
    @(posedge clock_200);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 1'b0; bus.wr_clock_en = 1'b0; bus.rd_clock_en = 1'b0;
    bus.wr_address = 4'd0; bus.rd_address = 4'd0; bus.data = 24'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clock_200);
    #1;
    checks++;
    if (bus.q !== 24'd0) begin
      failures++;
      $display("FAIL reset_q_held actual=%h expected=%h", bus.q, 24'd0);
    end
    reset_n = 1'b1;
    bus.rd_clock_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.rd_address = 4'(a);
      cycle();
      checks++;
      if (bus.q !== 24'd0) begin
        failures++;
        $display("FAIL reset_sweep addr=%0d actual=%h expected=%h", a, bus.q, 24'd0);
      end
    end
  endtask

  task automatic test_pipelined();
    bus.we = 1'b1; bus.wr_clock_en = 1'b1; bus.rd_clock_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_address = 4'(i);
      bus.data       = 24'(i * 1000);
      bus.rd_address = 4'((i + 15) % 16);
      cycle();
      checks++;
      if (bus.q !== 24'((i == 0) ? 0 : (i - 1) * 1000) || bus.q !== q_exp) begin
        failures++;
        $display("FAIL pipelined step=%0d actual=%h expected=%h", i, bus.q, q_exp);
      end
    end
    bus.we = 1'b0; bus.wr_clock_en = 1'b0;
  endtask

  task automatic test_read_hold();
    logic [23:0] held;
    held = q_exp;
    bus.rd_clock_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rd_address = 4'(i);
      cycle();
      checks++;
      if (bus.q !== held) begin
        failures++;
        $display("FAIL read_hold addr=%0d actual=%h expected=%h", i, bus.q, held);
      end
    end
    bus.rd_clock_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.rd_address = 4'(i);
      cycle();
      checks++;
      if (bus.q !== 24'(i * 1000)) begin
        failures++;
        $display("FAIL read_resume addr=%0d actual=%h expected=%h", i, bus.q, 24'(i * 1000));
      end
    end
  endtask

  task automatic test_write_gating();
    bus.rd_clock_en = 1'b0;
    bus.wr_address = 4'd3;
    bus.data = 24'hFFFFFF;
    bus.we = 1'b1; bus.wr_clock_en = 1'b0; cycle();
    bus.we = 1'b0; bus.wr_clock_en = 1'b1; cycle();
    bus.data = 'x;
    bus.we = 1'b0; bus.wr_clock_en = 1'b0; cycle();
    bus.we = 1'b0; bus.wr_clock_en = 1'b1; cycle();
    bus.wr_clock_en = 1'b0;
    bus.data = 24'd0;
    bus.rd_clock_en = 1'b1;
    bus.rd_address = 4'd3;
    cycle();
    checks++;
    if (bus.q !== 24'd3000) begin
      failures++;
      $display("FAIL write_gating actual=%h expected=%h", bus.q, 24'd3000);
    end
  endtask

  task automatic test_collision();
    logic [23:0] exp_first;
    exp_first = BYPASS ? 24'hABCDEF : 24'd5000;
    bus.rd_clock_en = 1'b1;
    bus.we = 1'b1; bus.wr_clock_en = 1'b1;
    bus.wr_address = 4'd5; bus.rd_address = 4'd5; bus.data = 24'hABCDEF;
    cycle();
    checks++;
    if (bus.q !== exp_first) begin
      failures++;
      $display("FAIL collision_same_edge actual=%h expected=%h", bus.q, exp_first);
    end
    bus.we = 1'b0; bus.wr_clock_en = 1'b0;
    cycle();
    checks++;
    if (bus.q !== 24'hABCDEF) begin
      failures++;
      $display("FAIL collision_next_read actual=%h expected=%h", bus.q, 24'hABCDEF);
    end
  endtask

  task automatic test_mid_reset();
    // In-flight write on the edge covered by reset must be lost.
    bus.we = 1'b1; bus.wr_clock_en = 1'b1;
    bus.wr_address = 4'd2; bus.data = 24'h123456;
    bus.rd_clock_en = 1'b1; bus.rd_address = 4'd5;
    #2;
    reset_n = 1'b0;
    #1;
    clear_model();
    checks++;
    if (bus.q !== 24'd0) begin
      failures++;
      $display("FAIL mid_reset_immediate actual=%h expected=%h", bus.q, 24'd0);
    end
    @(posedge clock_200);
    #1;
    reset_n = 1'b1;
    bus.we = 1'b0; bus.wr_clock_en = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bus.rd_address = 4'(a);
      cycle();
      checks++;
      if (bus.q !== 24'd0) begin
        failures++;
        $display("FAIL mid_reset_sweep addr=%0d actual=%h expected=%h", a, bus.q, 24'd0);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.we          = 1'($urandom_range(0, 3) != 0);
      bus.wr_clock_en = 1'($urandom_range(0, 3) != 0);
      bus.rd_clock_en = 1'($urandom_range(0, 3) != 0);
      bus.wr_address  = 4'($urandom_range(0, 15));
      bus.rd_address  = ($urandom_range(0, 3) == 0) ? bus.wr_address : 4'($urandom_range(0, 15));
      bus.data        = 24'($urandom);
      cycle();
      checks++;
      if (bus.q !== q_exp) begin
        failures++;
        $display("FAIL random n=%0d actual=%h expected=%h", n, bus.q, q_exp);
      end
    end
    idle_inputs();
    bus.rd_clock_en = 1'b1;
    for (int a = 0; a < 16; a++) begin
      bus.rd_address = 4'(a);
      cycle();
      checks++;
      if (bus.q !== q_exp) begin
        failures++;
        $display("FAIL random_dump addr=%0d actual=%h expected=%h", a, bus.q, q_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pipelined();
    test_read_hold();
    test_write_gating();
    test_collision();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/state_ram_24x16.md
# state_ram_24x16

Single-clock 16-word by 24-bit simple dual-port RAM with one write port, one read port and a registered read output. Holds per-slot state values for the slice datapath. Add/subtract results are written back through the write port while the next slot's state is read through the read port in the same cycle. Implemented in flops so that reset can clear both the array and the output register.

## Interface
- DATA_W, 24: word width; fixed at 24 for this block.
- ADDR_W, 4: address width; depth is 2**ADDR_W = 16.
- clock_200  input  1  single clock for both ports; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_address  input  4  write word address.
- data  input  24  write data.
- we  input  1  write enable.
- wr_clock_en  input  1  write-port clock enable; a write requires we=1 and wr_clock_en=1.
- rd_address  input  4  read word address.
- rd_clock_en  input  1  read-port clock enable; gates the output register.
- q  output  24  registered read data.

## Operation
- Reset (reset_n=0), asynchronous:
  - all 16 words clear to 0 immediately;
  - q clears to 0 immediately;
  - writes and reads are ignored while reset is held.
- Write: on a rising edge with we=1 and wr_clock_en=1, mem[wr_address] takes data. Any other enable combination leaves the array unchanged.
- Read:
  - on a rising edge with rd_clock_en=1, q takes mem[rd_address];
  - with rd_clock_en=0, q holds its last value regardless of rd_address changes.
- Ports are independent; both may operate on the same edge at any addresses.
- Read-during-write to the same address on the same edge is defined in Configuration.
- X on data with the write disabled must not corrupt the array.
- Addresses are full-range 4-bit; there is no out-of-range case and no wrap logic.

## Timing
- Write latency: data is stored at edge N and is visible to a read sampled at edge N+1, appearing on q after that edge.
- Read latency: 1 cycle. The address presented before edge N appears on q just after edge N.
- Reset deassertion: first effective write or read occurs at the first rising edge with reset_n=1.
- Reset asserted mid-operation: q and the array go to 0 without waiting for a clock edge. An in-flight write on that edge is lost.
- No handshake; enables are sampled every edge.

## Configuration
- RAM_BYPASS_EN defined: on a same-edge read and write to the same address (both enabled), q takes the new data (write-first).
- RAM_BYPASS_EN undefined (default): q takes the pre-write contents (read-first), and the new word is readable from the next edge.
- Behaviour is identical under both settings when addresses differ or either port is disabled.

## Test plan
- Reset check: drive reset_n=0 for 2 cycles, then release with rd_clock_en=1 and sweep rd_address 0..15 -> q=0 for every address.
- Pipelined write/read: with we=wr_clock_en=rd_clock_en=1, write 0,1000,…,9000 to addresses 0..9, one per cycle, with rd_address = wr_address−1 -> each cycle q shows the word written on the previous edge (0, 1000, …, 8000).
- Read hold: set rd_clock_en=0 and step rd_address 0..9 -> q stays at its last value. Then set rd_clock_en=1 and step rd_address 0..9 -> q=0,1000,…,9000, each one cycle after its address.
- Write gating: set we=1 with wr_clock_en=0 (and separately we=0 with wr_clock_en=1) and data=24'hFFFFFF at address 3 -> readback of address 3 is still 3000.
- Same-address collision: address 5 holds 5000; write 24'hABCDEF to address 5 while reading address 5 -> q=5000 without RAM_BYPASS_EN, q=24'hABCDEF with it. The next read returns 24'hABCDEF in both cases.
- Mid-operation reset: pulse reset_n low between edges after the fill -> q=0 immediately, and every address reads 0 afterwards.
